// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_unit_if
//  Description : Control bundle between the multi-cycle datapath (master) and
//                the main control unit (slave). Opcode and memory-ready flow
//                into the controller; datapath strobes and status flow out.
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_control_unit_if #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3
);
    logic [OP_W-1:0]     instr_op_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                pc_write_cond_o;
    logic                ir_write_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                iord_o;
    logic                mem_to_reg_o;
    logic                reg_dst_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [1:0]          pc_source_o;
    logic                illegal_o;
    logic                mem_timeout_o;
    logic [3:0]          state_o;

    // Datapath side: supplies opcode and memory status, consumes controls.
    modport master (
        output instr_op_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o,
               iord_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, illegal_o, mem_timeout_o,
               state_o
    );

    // Controller side.
    modport slave (
        input  instr_op_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o,
               iord_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, illegal_o, mem_timeout_o,
               state_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_unit
//  Description : Multi-cycle MIPS main control FSM (fetch/decode/execute/
//                memory/write-back) with immediate ALU ops, memory-ready wait
//                with timeout and illegal-opcode reporting.
//                Optional macro MC_JUMP_EN adds the j (opcode 0x02) state.
//                The interface instance must use the same OP_W / ALU_OP_W.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control_unit #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 15
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    mc_control_unit_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
`ifdef MC_JUMP_EN
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
`endif

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2'b10);

    typedef enum logic [3:0] {
        S_RST = 4'd0,  S_IF  = 4'd1,  S_ID  = 4'd2,  S_MA  = 4'd3,
        S_MRD = 4'd4,  S_MWB = 4'd5,  S_MWR = 4'd6,  S_EXR = 4'd7,
        S_WBR = 4'd8,  S_BR  = 4'd9,  S_EXI = 4'd10, S_WBI = 4'd11,
`ifdef MC_JUMP_EN
        S_JMP = 4'd12,
`endif
        S_ILL = 4'd13
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                timeout_hit;
    logic                wait_state;

    logic                pc_write_q, pc_write_cond_q, mem_read_q, mem_write_q;
    logic                iord_q, mem_to_reg_q, reg_dst_q, reg_write_q, alu_src_a_q;
    logic [1:0]          alu_src_b_q, pc_source_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                illegal_q, mem_timeout_q;

    // Next-state logic; a memory-wait timeout overrides any transition.
    always_comb begin
        wait_state  = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
        timeout_hit = TO_EN && wait_state && !bus.mem_ready_i &&
                      (wait_cnt_q == CNT_W'(TIMEOUT));
        state_d     = S_RST;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF:  state_d = bus.mem_ready_i ? S_ID : S_IF;
            S_ID: begin
                if      (bus.instr_op_i == OP_RTYPE) state_d = S_EXR;
                else if (bus.instr_op_i == OP_LW)    state_d = S_MA;
                else if (bus.instr_op_i == OP_SW)    state_d = S_MA;
                else if (bus.instr_op_i == OP_BEQ)   state_d = S_BR;
                else if (bus.instr_op_i == OP_ADDI)  state_d = S_EXI;
`ifdef MC_JUMP_EN
                else if (bus.instr_op_i == OP_J)     state_d = S_JMP;
`endif
                else                                 state_d = S_ILL;
            end
            // IR is stable, so the opcode can be re-read to pick load vs store.
            S_MA:  state_d = (bus.instr_op_i == OP_LW) ? S_MRD : S_MWR;
            S_MRD: state_d = bus.mem_ready_i ? S_MWB : S_MRD;
            S_MWR: state_d = bus.mem_ready_i ? S_IF : S_MWR;
            S_EXR: state_d = S_WBR;
            S_EXI: state_d = S_WBI;
            S_MWB, S_WBR, S_WBI, S_BR, S_ILL: state_d = S_IF;
`ifdef MC_JUMP_EN
            S_JMP: state_d = S_IF;
`endif
            default: state_d = S_RST;
        endcase
        if (timeout_hit) begin
            state_d = S_IF;
        end
    end

    // State, wait counter and Moore outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= S_RST;
            wait_cnt_q      <= '0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            iord_q          <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= '0;
            pc_source_q     <= 2'b00;
            illegal_q       <= 1'b0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= timeout_hit;

            // Counter restarts on every entry to a wait state (including the
            // IF->IF re-entry after a timeout) and counts only stalled cycles.
            if (!TO_EN || timeout_hit || !wait_state || state_d != state_q ||
                bus.mem_ready_i) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end

            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            iord_q          <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= ALU_ADD;
            pc_source_q     <= 2'b00;
            illegal_q       <= 1'b0;
            case (state_d)
                S_IF:  begin mem_read_q <= 1'b1; alu_src_b_q <= 2'b01; end
                S_ID:  alu_src_b_q <= 2'b11;
                S_MA, S_EXI: begin alu_src_a_q <= 1'b1; alu_src_b_q <= 2'b10; end
                S_MRD: begin mem_read_q <= 1'b1; iord_q <= 1'b1; end
                S_MWR: begin mem_write_q <= 1'b1; iord_q <= 1'b1; end
                S_MWB: begin reg_write_q <= 1'b1; mem_to_reg_q <= 1'b1; end
                S_EXR: begin alu_src_a_q <= 1'b1; alu_op_q <= ALU_FUNCT; end
                S_WBR: begin reg_write_q <= 1'b1; reg_dst_q <= 1'b1; end
                S_WBI: reg_write_q <= 1'b1;
                S_BR: begin
                    alu_src_a_q     <= 1'b1;
                    alu_op_q        <= ALU_SUB;
                    pc_write_cond_q <= 1'b1;
                    pc_source_q     <= 2'b01;
                end
`ifdef MC_JUMP_EN
                S_JMP: begin pc_write_q <= 1'b1; pc_source_q <= 2'b10; end
`endif
                S_ILL: illegal_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch strobes are the only outputs qualified combinationally by ready.
    assign bus.ir_write_o      = (state_q == S_IF) && bus.mem_ready_i;
    assign bus.pc_write_o      = bus.ir_write_o || pc_write_q;
    assign bus.pc_write_cond_o = pc_write_cond_q;
    assign bus.mem_read_o      = mem_read_q;
    assign bus.mem_write_o     = mem_write_q;
    assign bus.iord_o          = iord_q;
    assign bus.mem_to_reg_o    = mem_to_reg_q;
    assign bus.reg_dst_o       = reg_dst_q;
    assign bus.reg_write_o     = reg_write_q;
    assign bus.alu_src_a_o     = alu_src_a_q;
    assign bus.alu_src_b_o     = alu_src_b_q;
    assign bus.alu_op_o        = alu_op_q;
    assign bus.pc_source_o     = pc_source_q;
    assign bus.illegal_o       = illegal_q;
    assign bus.mem_timeout_o   = mem_timeout_q;
    assign bus.state_o         = state_q;
endmodule
`default_nettype wire
